decim3_acc: RTL and testbench

DECIM3_ACC -- requirements
Module: decim3_acc

---
 rtl/decim3_acc_pkg.sv | 12 +
 rtl/decim3_acc_if.sv | 26 ++
 rtl/decim3_acc_phase_cnt.sv | 29 ++
 rtl/decim3_acc.sv | 92 +++++++++
 tb/tb_decim3_acc.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/decim3_acc_pkg.sv
// Shared DFE constants: sample widths, decimation factor and phase type.
`default_nettype none

package dfe_pkg;
  localparam int DATA_W       = 16;
  localparam int OUT_W        = DATA_W + 2;
  localparam int DECIM_FACTOR = 3;

  typedef logic [1:0] phase_t;
endpackage

`default_nettype wire

// File: rtl/decim3_acc_if.sv
// Valid/ready sample stream in and result stream out of the decimator.
`default_nettype none

interface decim3_acc_if #(
  parameter int DATA_W = dfe_pkg::DATA_W,
  parameter int OUT_W  = DATA_W + 2
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/decim3_acc_phase_cnt.sv
// Mod-DECIM_FACTOR phase counter; clear restarts the count, honouring a same-cycle advance.
`default_nettype none

module decim_phase_cnt
  import dfe_pkg::*;
(
  input  logic   clk_in,
  input  logic   rst,
  input  logic   advance,
  input  logic   clear,
  output phase_t phase
);

  localparam phase_t LAST = phase_t'(DECIM_FACTOR - 1);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      phase <= '0;
    end else if (clear) begin
      // The sample arriving on a clear edge becomes phase 0 of the new group.
      phase <= advance ? phase_t'(1) : '0;
    end else if (advance) begin
      phase <= (phase == LAST) ? '0 : phase + phase_t'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/decim3_acc.sv
// Decimate-by-3 accumulator (sum of three samples) with a sign-extending bypass mode.
`default_nettype none

module decim3_acc #(
  parameter int DATA_W = dfe_pkg::DATA_W,
  parameter int OUT_W  = DATA_W + 2
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         EN,
  decim3_acc_if.slave  bus
);

  import dfe_pkg::*;

  generate
    if (OUT_W != DATA_W + 2) begin : g_out_w_check
      $error("decim3_acc: OUT_W must equal DATA_W+2");
    end
  endgenerate

  localparam phase_t LAST = phase_t'(DECIM_FACTOR - 1);

  logic                    en_q;
  logic                    en_change;
  logic                    in_fire;
  logic                    out_fire;
  logic                    load;
  phase_t                  phase;
  phase_t                  eff_phase;
  logic signed [OUT_W-1:0] sample;
  logic signed [OUT_W-1:0] acc;
  logic signed [OUT_W-1:0] sum;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = bus.out_valid && bus.out_ready;
  assign en_change    = (EN != en_q);
  assign sample       = OUT_W'($signed(bus.in_data));
  assign sum          = acc + sample;

  // A mode change discards the partial group, so this edge counts as phase 0.
  assign eff_phase = en_change ? '0 : phase;
  assign load      = in_fire && (!EN || (eff_phase == LAST));

  decim_phase_cnt u_phase (
    .clk_in  (clk_in),
    .rst     (rst),
    .advance (in_fire && EN),
    .clear   (en_change),
    .phase   (phase)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      en_q <= 1'b0;
    end else begin
      en_q <= EN;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst || !EN) begin
      acc <= '0;
    end else if (in_fire) begin
      if (eff_phase == '0) begin
        acc <= sample;
      end else if (load) begin
        acc <= '0;
      end else begin
        acc <= sum;
      end
    end else if (en_change) begin
      acc <= '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= EN ? sum : sample;
    end else if (out_fire) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decim3_acc.sv
// Self-checking bench: directed vector table, corner sequences and random traffic vs a group-sum model.
`default_nettype none

module tb_decim3_acc;
  import dfe_pkg::*;

  localparam int DW = DATA_W;
  localparam int OW = OUT_W;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  logic en     = 1'b0;

  decim3_acc_if #(.DATA_W(DW), .OUT_W(OW)) bus ();

  decim3_acc #(.DATA_W(DW), .OUT_W(OW)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .EN     (en),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: pending group samples plus the held result.
  logic m_valid;
  int   m_data;
  logic m_en_prev;
  int   grp[$];

  logic cur_en, cur_iv, cur_ordy, cur_rst;
  int   cur_d;

  typedef struct {
    logic en;
    logic iv;
    int   d;
    logic ordy;
    logic exp_rdy;
    logic exp_vld;
    int   exp_data;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid   = 1'b0;
    m_data    = 0;
    m_en_prev = 1'b0;
    grp.delete();
  endtask

  task automatic apply(input logic e, input logic v, input int d, input logic ordy, input logic r);
    en           = e;
    bus.in_valid = v;
    bus.in_data  = DW'(d);
    bus.out_ready = ordy;
    rst          = r;
    cur_en = e; cur_iv = v; cur_d = d; cur_ordy = ordy; cur_rst = r;
    #1;
    check("model_in_ready", int'(bus.in_ready), int'(!m_valid || ordy));
    check("model_out_valid", int'(bus.out_valid), int'(m_valid));
    if (m_valid) check("model_out_data", int'($signed(bus.out_data)), m_data);
  endtask

  task automatic tick();
    logic fire_in, fire_out, ld;
    int   res, s;
    if (cur_rst) begin
      model_reset();
    end else begin
      fire_in  = cur_iv && (!m_valid || cur_ordy);
      fire_out = m_valid && cur_ordy;
      ld  = 1'b0;
      res = 0;
      if (cur_en != m_en_prev) grp.delete();
      m_en_prev = cur_en;
      if (fire_in) begin
        if (!cur_en) begin
          res = cur_d;
          ld  = 1'b1;
        end else begin
          grp.push_back(cur_d);
          if (grp.size() == DECIM_FACTOR) begin
            s = 0;
            foreach (grp[i]) s += grp[i];
            res = s;
            ld  = 1'b1;
            grp.delete();
          end
        end
      end
      if (ld) begin
        m_valid = 1'b1;
        m_data  = res;
      end else if (fire_out) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic addv(input logic e, input logic v, input int d, input logic ordy,
                      input logic xr, input logic xv, input int xd);
    vec_t t;
    t.en = e; t.iv = v; t.d = d; t.ordy = ordy;
    t.exp_rdy = xr; t.exp_vld = xv; t.exp_data = xd;
    tbl.push_back(t);
  endtask

  initial begin
    logic e, v, o, r;
    int   d;
    logic signed [15:0] rnd;

    // Basic decimation, 1..6 -> 6, 15
    addv(1, 1, 1, 1, 1, 0, 0);
    addv(1, 1, 2, 1, 1, 0, 0);
    addv(1, 1, 3, 1, 1, 0, 0);
    addv(1, 1, 4, 1, 1, 1, 6);
    addv(1, 1, 5, 1, 1, 0, 0);
    addv(1, 1, 6, 1, 1, 0, 0);
    addv(1, 0, 0, 1, 1, 1, 15);
    addv(1, 0, 0, 1, 1, 0, 0);
    // Backpressure holds the result and stalls input 4
    addv(1, 1, 1, 0, 1, 0, 0);
    addv(1, 1, 2, 0, 1, 0, 0);
    addv(1, 1, 3, 0, 1, 0, 0);
    addv(1, 1, 4, 0, 0, 1, 6);
    addv(1, 1, 4, 0, 0, 1, 6);
    addv(1, 1, 4, 1, 1, 1, 6);
    addv(1, 1, 5, 1, 1, 0, 0);
    addv(1, 1, 6, 1, 1, 0, 0);
    addv(1, 0, 0, 1, 1, 1, 15);
    addv(1, 0, 0, 1, 1, 0, 0);
    // Bypass, back-to-back results without a bubble
    addv(0, 0, 0, 1, 1, 0, 0);
    addv(0, 1, -5, 1, 1, 0, 0);
    addv(0, 1, 7, 1, 1, 1, -5);
    addv(0, 0, 0, 1, 1, 1, 7);
    addv(0, 0, 0, 1, 1, 0, 0);

    rst = 1'b1; en = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    cur_rst = 1'b1; cur_en = 1'b1; cur_iv = 1'b0; cur_d = 0; cur_ordy = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_data", int'(bus.out_data), 0);

    foreach (tbl[k]) begin
      apply(tbl[k].en, tbl[k].iv, tbl[k].d, tbl[k].ordy, 1'b0);
      check($sformatf("tbl%0d_in_ready", k), int'(bus.in_ready), int'(tbl[k].exp_rdy));
      check($sformatf("tbl%0d_out_valid", k), int'(bus.out_valid), int'(tbl[k].exp_vld));
      if (tbl[k].exp_vld)
        check($sformatf("tbl%0d_out_data", k), int'($signed(bus.out_data)), tbl[k].exp_data);
      tick();
    end

    // Full-scale negative and positive groups
    apply(1, 0, 0, 1, 0); tick();
    repeat (3) begin apply(1, 1, -32768, 1, 0); tick(); end
    apply(1, 0, 0, 1, 0);
    check("sum_min", int'($signed(bus.out_data)), -98304);
    check("sum_min_raw", int'(bus.out_data), 'h28000);
    tick();
    repeat (3) begin apply(1, 1, 32767, 1, 0); tick(); end
    apply(1, 0, 0, 1, 0);
    check("sum_max", int'($signed(bus.out_data)), 98301);
    tick();

    // Partial group discarded when EN drops, fresh group after restore
    apply(1, 1, 10, 1, 0); tick();
    apply(1, 1, 20, 1, 0); tick();
    apply(0, 0, 0, 1, 0); tick();
    apply(0, 1, 3, 1, 0); tick();
    apply(0, 0, 0, 1, 0);
    check("en_drop_valid", int'(bus.out_valid), 1);
    check("en_drop_data", int'($signed(bus.out_data)), 3);
    tick();
    apply(0, 0, 0, 1, 0);
    check("en_drop_no_partial", int'(bus.out_valid), 0);
    tick();
    apply(1, 0, 0, 1, 0); tick();
    apply(1, 1, 1, 1, 0); tick();
    apply(1, 1, 2, 1, 0); tick();
    apply(1, 1, 3, 1, 0); tick();
    apply(1, 0, 0, 1, 0);
    check("en_restore_data", int'($signed(bus.out_data)), 6);
    tick();

    // Reset mid-group
    apply(1, 1, 5, 1, 0); tick();
    apply(1, 1, 6, 1, 0); tick();
    apply(1, 1, 7, 1, 1); tick();
    apply(1, 1, 7, 1, 1);
    check("rst_mid_valid", int'(bus.out_valid), 0);
    tick();
    apply(1, 1, 1, 1, 0);
    check("post_rst_ready", int'(bus.in_ready), 1);
    check("post_rst_valid", int'(bus.out_valid), 0);
    tick();
    apply(1, 1, 1, 1, 0); tick();
    apply(1, 1, 1, 1, 0); tick();
    apply(1, 0, 0, 1, 0);
    check("post_rst_valid2", int'(bus.out_valid), 1);
    check("post_rst_data", int'($signed(bus.out_data)), 3);
    tick();

    // Random traffic
    e = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 9) < 7);
      o = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) begin
        e = ~e;
        v = 1'b0;
      end
      case ($urandom_range(0, 7))
        0:       d = -32768;
        1:       d = 32767;
        default: begin rnd = 16'($urandom); d = int'(rnd); end
      endcase
      apply(e, v, d, o, r);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
